pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-data stalls, memory-busy freeze, interrupt accept.
// Outputs are combinational from state and inputs; stall_cnt is a registered saturating counter.
module pipe_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_memrd,
  input  logic             ex_regwrite,
  input  logic [AW-1:0]    ex_wdst,
  input  logic             mem_busy,
  input  logic             irq,
  input  logic             irq_en,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_clear,
  output logic             id_ex_stall,
  output logic             id_ex_clear,
  output logic             ex_mem_stall,
  output logic             irq_take,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, LOAD_WAIT, MEM_WAIT} state_t;

  state_t     state, state_nx, ret_state, ret_nx, eff_state;
  logic [1:0] bub_cnt, bub_nx;
  logic       pending, pending_nx, irq_q;
  logic       src_match, load_use, br_haz, irq_edge;
  logic       pc_stall_c, if_id_stall_c, if_id_clear_c;
  logic       id_ex_stall_c, id_ex_clear_c, ex_mem_stall_c, irq_take_c;

  assign src_match = (ex_wdst != '0) &&
                     ((id_uses_rs && (id_rs == ex_wdst)) ||
                      (id_uses_rt && (id_rt == ex_wdst)));
  assign load_use  = ex_memrd & ex_regwrite & src_match;
  assign br_haz    = id_branch & ex_regwrite & ~ex_memrd & src_match;
  assign irq_edge  = irq & ~irq_q & irq_en;

  always_comb begin
    state_nx       = state;
    ret_nx         = ret_state;
    bub_nx         = bub_cnt;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_clear_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_clear_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    irq_take_c     = 1'b0;
    // Leaving MEM_WAIT resumes the stored state within the same cycle.
    eff_state      = (state == MEM_WAIT) ? ret_state : state;

    if (mem_busy) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      state_nx       = MEM_WAIT;
      ret_nx         = eff_state;
    end else begin
      state_nx = eff_state;
      if (eff_state == LOAD_WAIT) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_clear_c = 1'b1;
        if (bub_cnt <= 2'd1) begin
          bub_nx   = 2'd0;
          state_nx = RUN;
        end else begin
          bub_nx = bub_cnt - 2'd1;
        end
      end else if (load_use || br_haz) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_clear_c = 1'b1;
        if (load_use && (LOAD_STALL > 1)) begin
          bub_nx   = 2'(LOAD_STALL - 1);
          state_nx = LOAD_WAIT;
        end
      end else if (pending) begin
        irq_take_c    = 1'b1;
        if_id_clear_c = 1'b1;
        id_ex_clear_c = 1'b1;
      end else if (id_jump || (id_branch && id_branch_taken)) begin
        if_id_clear_c = 1'b1;
      end
    end

    if (!irq_en)       pending_nx = 1'b0;
    else if (irq_edge) pending_nx = 1'b1;
    else if (irq_take_c) pending_nx = 1'b0;
    else               pending_nx = pending;
  end

  // Gate with reset so outputs drop immediately on an asynchronous assert.
  assign pc_stall     = pc_stall_c     & ~reset;
  assign if_id_stall  = if_id_stall_c  & ~reset;
  assign if_id_clear  = if_id_clear_c  & ~reset;
  assign id_ex_stall  = id_ex_stall_c  & ~reset;
  assign id_ex_clear  = id_ex_clear_c  & ~reset;
  assign ex_mem_stall = ex_mem_stall_c & ~reset;
  assign irq_take     = irq_take_c     & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      bub_cnt   <= 2'd0;
      pending   <= 1'b0;
      irq_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      bub_cnt   <= bub_nx;
      pending   <= pending_nx;
      irq_q     <= irq;
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
